// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler sharing one uart_byte_tx between two byte-stream requesters.
// Frame on the wire: SYNC, id, len, payload[len], sum(id + len + payload) mod 256.
module uart_tx_sched #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] len_0,
  input  logic [DATA_W-1:0] len_1,
  input  logic [DATA_W-1:0] dat_0,
  input  logic [DATA_W-1:0] dat_1,
  output logic              pop_0,
  output logic              pop_1,
  output logic              done_0,
  output logic              done_1,
  output logic              busy,
  output logic              byte_en,
  output logic [DATA_W-1:0] data_byte,
  input  logic              tx_done
);

  localparam logic [DATA_W-1:0] SYNC = DATA_W'(8'hA5);

  typedef enum logic [1:0] {IDLE, STRB, WAIT} state_t;
  typedef enum logic [2:0] {F_SYNC, F_ID, F_LEN, F_PAY, F_SUM} field_t;

  state_t            state, state_nxt;
  field_t            field;
  logic              grant, last_srv;
  logic [DATA_W-1:0] len_r, cnt, sum;

  logic              start, advance, take_pay, pick;
  logic [DATA_W-1:0] cur_dat, id_byte;

  function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_nxt = STRB;
        start     = 1'b1;
      end
      STRB: state_nxt = WAIT;
      WAIT: if (tx_done) begin
        advance   = 1'b1;
        state_nxt = (field == F_SUM) ? IDLE : STRB;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_en = (state == STRB);
    busy    = (state != IDLE);
  end

  // Tie goes to the requester not served last; a lone request always wins.
  assign pick     = (req == 2'b11) ? ~last_srv : req[1];
  assign cur_dat  = grant ? dat_1 : dat_0;
  assign id_byte  = {{(DATA_W-1){1'b0}}, grant};
  assign take_pay = ((field == F_LEN) && (len_r != '0)) ||
                    ((field == F_PAY) && (cnt != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field     <= F_SYNC;
      grant     <= 1'b0;
      last_srv  <= 1'b1;
      len_r     <= '0;
      cnt       <= '0;
      sum       <= '0;
      data_byte <= '0;
      pop_0     <= 1'b0;
      pop_1     <= 1'b0;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
    end else begin
      pop_0  <= 1'b0;
      pop_1  <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      if (start) begin
        grant     <= pick;
        len_r     <= pick ? len_1 : len_0;
        sum       <= '0;
        data_byte <= SYNC;
        field     <= F_SYNC;
      end else if (advance) begin
        case (field)
          F_SYNC: begin
            data_byte <= id_byte;
            sum       <= sum_wrap(sum, id_byte);
            field     <= F_ID;
          end
          F_ID: begin
            data_byte <= len_r;
            sum       <= sum_wrap(sum, len_r);
            field     <= F_LEN;
          end
          F_LEN, F_PAY: begin
            // cnt holds the payload bytes still to load after the current one
            if (take_pay) begin
              data_byte <= cur_dat;
              sum       <= sum_wrap(sum, cur_dat);
              cnt       <= (field == F_LEN) ? len_r - 1'b1 : cnt - 1'b1;
              pop_0     <= ~grant;
              pop_1     <= grant;
              field     <= F_PAY;
            end else begin
              data_byte <= sum;
              field     <= F_SUM;
            end
          end
          F_SUM: begin
            done_0   <= ~grant;
            done_1   <= grant;
            last_srv <= grant;
            field    <= F_SYNC;
          end
          default: field <= F_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: uart_byte_tx and requester models, frame-level reference model.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] len_0 = 8'h00, len_1 = 8'h00, dat_0 = 8'h00, dat_1 = 8'h00;
  logic       pop_0, pop_1, done_0, done_1, busy, byte_en;
  logic [7:0] data_byte;
  logic       tx_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_sched dut (
    .clk(clk), .rst(rst), .req(req),
    .len_0(len_0), .len_1(len_1), .dat_0(dat_0), .dat_1(dat_1),
    .pop_0(pop_0), .pop_1(pop_1), .done_0(done_0), .done_1(done_1),
    .busy(busy), .byte_en(byte_en), .data_byte(data_byte), .tx_done(tx_done)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment state: payload sources, transmitted bytes, event counters
  logic [7:0] pq0[$], pq1[$], rx_q[$];
  int         pops0 = 0, pops1 = 0, dones0 = 0, dones1 = 0;
  int         cd = 0;
  logic [7:0] held = 8'h00;
  logic       prev_be = 1'b0, td_real_prev = 1'b0, spur_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cd           = 0;
      tx_done      = 1'b0;
      prev_be      = 1'b0;
      td_real_prev = 1'b0;
    end else begin
      if (td_real_prev) chk("no_gap_after_tx_done", byte_en | done_0 | done_1, 1);
      td_real_prev = 1'b0;
      tx_done      = 1'b0;
      if (byte_en) begin
        chk("byte_en_width", prev_be, 0);
        rx_q.push_back(data_byte);
        held = data_byte;
        cd   = $urandom_range(1, 4);
        if (spur_en) tx_done = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk("data_byte_stable", data_byte, held);
          tx_done      = 1'b1;
          td_real_prev = 1'b1;
        end
      end
      prev_be = byte_en;
      if (pop_0) begin
        chk("pop0_with_byte_en", byte_en, 1);
        pops0++;
        if (pq0.size() != 0) void'(pq0.pop_front());
      end
      if (pop_1) begin
        chk("pop1_with_byte_en", byte_en, 1);
        pops1++;
        if (pq1.size() != 0) void'(pq1.pop_front());
      end
      if (done_0) dones0++;
      if (done_1) dones1++;
    end
    dat_0 = (pq0.size() != 0) ? pq0[0] : 8'h00;
    dat_1 = (pq1.size() != 0) ? pq1[0] : 8'h00;
  end

  // Reference model: expected wire bytes and event counts per frame
  logic [7:0] mp0[$], mp1[$], exp_q[$];
  int         exp_pops0 = 0, exp_pops1 = 0, exp_dones0 = 0, exp_dones1 = 0;
  logic       last_srv = 1'b1;

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return last_srv ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic push_pay(input int ch, input logic [7:0] b);
    if (ch == 1) begin pq1.push_back(b); mp1.push_back(b); end
    else         begin pq0.push_back(b); mp0.push_back(b); end
  endtask

  task automatic model_frame(input int ch);
    logic [7:0] l, s, b;
    l = (ch == 1) ? len_1 : len_0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(l);
    s = 8'(ch) + l;
    for (int i = 0; i < int'(l); i++) begin
      b = (ch == 1) ? mp1.pop_front() : mp0.pop_front();
      exp_q.push_back(b);
      s = s + b;
    end
    exp_q.push_back(s);
    if (ch == 1) begin exp_pops1 += int'(l); exp_dones1++; end
    else         begin exp_pops0 += int'(l); exp_dones0++; end
    last_srv = (ch == 1);
  endtask

  task automatic serve(input logic [1:0] r, input int nfr, input bit disturb);
    int  seen = 0, cyc = 0;
    bit  hit = 0;
    req = r;
    while (seen < nfr && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (disturb && !hit && pop_0) begin
        req   = 2'b00;
        len_0 = 8'd9;
        hit   = 1;
      end
      if (done_0 | done_1) begin
        seen++;
        chk("busy_low_at_done", busy, 0);
      end
    end
    req = 2'b00;
    chk("frames_completed", seen, nfr);
    @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    chk({tag, "_pops0"}, pops0, exp_pops0);
    chk({tag, "_pops1"}, pops1, exp_pops1);
    chk({tag, "_dones0"}, dones0, exp_dones0);
    chk({tag, "_dones1"}, dones1, exp_dones1);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_en"}, byte_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_data_byte"}, data_byte, 8'h00);
    chk({tag, "_pops"}, {pop_1, pop_0}, 0);
    chk({tag, "_dones"}, {done_1, done_0}, 0);
  endtask

  initial begin
    int         snap, ch, n;
    logic [1:0] r;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single frame, with grant latency
    push_pay(0, 8'h11); push_pay(0, 8'h22);
    len_0 = 8'd2;
    model_frame(0);
    req = 2'b01;
    @(negedge clk);
    chk("grant_byte_en", byte_en, 1);
    chk("grant_busy", busy, 1);
    chk("grant_sync", data_byte, 8'hA5);
    serve(2'b01, 1, 0);
    chk("single_sum", rx_q[rx_q.size()-1], 8'h35);
    check_frames("single");

    // Zero length
    len_1 = 8'd0;
    model_frame(1);
    serve(2'b10, 1, 0);
    check_frames("zero_len");

    // Tie and fairness after a fresh reset
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    last_srv = 1'b1;
    len_0 = 8'd1; len_1 = 8'd1;
    push_pay(0, 8'hAA); push_pay(0, 8'hAA); push_pay(1, 8'h55);
    for (int i = 0; i < 3; i++) model_frame(pick(2'b11));
    serve(2'b11, 3, 0);
    chk("tie_first_sum", rx_q[4], 8'hAB);
    chk("tie_second_sum", rx_q[9], 8'h57);
    check_frames("tie");

    // Checksum wrap
    len_0 = 8'd3;
    push_pay(0, 8'hFF); push_pay(0, 8'hFF); push_pay(0, 8'h03);
    model_frame(0);
    serve(2'b01, 1, 0);
    chk("wrap_sum", rx_q[rx_q.size()-1], 8'h04);
    check_frames("wrap");

    // Mid-frame req drop, len change and spurious tx_done
    len_0 = 8'd4;
    for (int i = 0; i < 4; i++) push_pay(0, 8'($urandom));
    model_frame(0);
    spur_en = 1'b1;
    serve(2'b01, 1, 1);
    spur_en = 1'b0;
    check_frames("disturb");
    chk("disturb_q_drained", pq0.size(), 0);

    // Reset during payload
    len_1 = 8'd6;
    for (int i = 0; i < 6; i++) push_pay(1, 8'($urandom));
    snap = dones0 + dones1;
    req  = 2'b10;
    n    = 0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      @(negedge clk);
      if (pop_1) n++;
    end
    chk("rst_reached_payload", n, 2);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", dones0 + dones1, snap);
    pq1.delete(); mp1.delete(); rx_q.delete(); exp_q.delete();
    exp_pops1 = pops1;
    last_srv  = 1'b1;
    len_0 = 8'd2;
    push_pay(0, 8'($urandom)); push_pay(0, 8'($urandom));
    model_frame(0);
    serve(2'b01, 1, 0);
    check_frames("after_rst");

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      r     = 2'($urandom_range(1, 3));
      len_0 = 8'($urandom_range(0, 12));
      len_1 = 8'($urandom_range(0, 12));
      for (int i = 0; i < int'(len_0); i++) push_pay(0, 8'($urandom));
      for (int i = 0; i < int'(len_1); i++) push_pay(1, 8'($urandom));
      ch = pick(r);
      model_frame(ch);
      serve(r, 1, 0);
      check_frames("rand");
      chk("rand_q_drained", (ch == 1) ? pq1.size() : pq0.size(), 0);
      pq0.delete(); pq1.delete(); mp0.delete(); mp1.delete();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Frame scheduler that shares one `uart_byte_tx` instance between two byte-stream requesters in the uart_scope design. It arbitrates round-robin, wraps each requester's payload in a framed packet (sync, channel id, length, payload, checksum), and sequences `uart_byte_tx` byte by byte through its `byte_en`/`tx_done` handshake. It sits between the scope capture/command logic and the UART transmitter; `baud_set` is wired directly to `uart_byte_tx` and does not pass through this block.

## Interface
- SYNC, 8'hA5, first byte of every frame
- clk  in  1  system clock (50 MHz); all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  level request per requester; bit 0 = channel 0, bit 1 = channel 1
- len_0, len_1  in  8  payload byte count per requester, 0..255; sampled only at grant
- dat_0, dat_1  in  8  current payload byte per requester (show-ahead); must be valid while that requester is granted
- pop_0, pop_1  out  1  one-cycle pulse: current `dat_x` consumed, present the next byte on the following cycle
- done_0, done_1  out  1  one-cycle pulse when the checksum byte of that requester's frame has finished transmitting
- busy  out  1  high from grant until frame end
- byte_en  out  1  one-cycle start strobe to `uart_byte_tx`
- data_byte  out  8  byte to `uart_byte_tx`; held stable from `byte_en` until `tx_done`
- tx_done  in  1  one-cycle pulse from `uart_byte_tx` when a byte has been sent

## Operation
- Frame format: SYNC, id (8'h00 or 8'h01), len, len payload bytes, sum. The checksum `sum` is the 8-bit wrap-around sum (mod 256) of id, len and all payload bytes. SYNC is not included in the sum.
- FSM states are IDLE, STRB, WAIT.
  - IDLE: if any `req` bit is high, grant one requester, latch grant and len, clear the checksum accumulator, load SYNC into `data_byte`, assert `byte_en`, and go to STRB.
  - STRB: deassert `byte_en` and go to WAIT. `byte_en` is therefore exactly one cycle wide.
  - WAIT: on `tx_done`, advance the field counter (SYNC→ID→LEN→PAY→SUM). Load the next byte, assert `byte_en`, and go to STRB.
  - WAIT, after the tx_done of SUM: pulse `done_x`, update the last-served pointer, and return to IDLE.
- When len = 0, the PAY field is skipped and LEN is followed directly by SUM.
- PAY: at each edge where a payload byte is loaded, `data_byte`<=`dat_x`, `pop_x`<=1, and the byte is added to the checksum. There are exactly len pops per frame.
- Arbitration is round-robin over a last-served pointer.
  - With a single request, that requester is granted.
  - With both requesting, the requester not served last is granted.
  - After reset the pointer is 1, so channel 0 wins the first tie.
- Grant and len are frozen for the whole frame. Deasserting `req` mid-frame does not abort the frame, and len changes mid-frame are ignored.
- A `tx_done` outside WAIT is ignored.

## Timing
- Reset values: `byte_en`=0, `data_byte`=8'h00, `pop_x`=0, `done_x`=0, `busy`=0, state=IDLE, pointer=1, checksum=0.
- Reset asserted mid-frame: all of the above take effect immediately. The partial frame is abandoned with no `done` pulse. `uart_byte_tx` is reset by the same `rst`.
- Grant latency: `req` sampled high at edge k in IDLE gives `byte_en`=1 and `busy`=1 in the cycle after edge k.
- Inter-byte: `tx_done` sampled at edge m gives `byte_en`=1 and new `data_byte` in the cycle after edge m. There is no extra gap.
- `pop_x` is high during the same cycle as the `byte_en` that carries that payload byte.
- `done_x` is high in the cycle after the final `tx_done`, and `busy` goes low at that same edge.
- IDLE lasts at least one cycle between frames. The earliest next `byte_en` is 2 cycles after the final `tx_done`.
- Checksum arithmetic is 8-bit with carry discarded. len is 8-bit, so the longest frame is 259 bytes.

## Test plan
- Single frame: ch0, len=2, dat sequence 8'h11, 8'h22 -> rx bytes A5 00 02 11 22 35; two `pop_0` pulses; one `done_0`; `byte_en` always 1 cycle wide.
- Zero length: ch1, len=0 -> A5 01 00 01; no `pop_1`; one `done_1`.
- Tie and fairness: both `req` held high after reset, len=1 each (dat_0=8'hAA, dat_1=8'h55) -> frames are ch0 (A5 00 01 AA AB), then ch1 (A5 01 01 55 57), then ch0.
- Checksum wrap: ch0, len=3, payload FF FF 03 -> sum byte 8'h04.
- Mid-frame disturbance: drop `req[0]` and change len_0 during payload -> frame completes with the original length. Inject a spurious `tx_done` in STRB -> ignored.
- Reset mid-frame: pulse `rst` low during the PAY field -> all outputs return to reset values, no `done` pulse. After release, a new request produces a complete, correct frame.
